// File: rtl/moving_average_pkg.sv
// Shared definitions for the moving_average filter: mode encodings, accumulator
// width and the per-mode decimation factor.
package moving_average_pkg;

    localparam int ACC_W = 20;
    localparam int CNT_W = 5;

    localparam logic [2:0] MODE_PASS  = 3'd0;
    localparam logic [2:0] MODE_AVG2  = 3'd1;
    localparam logic [2:0] MODE_WGT3  = 3'd2;
    localparam logic [2:0] MODE_AVG4  = 3'd3;
    localparam logic [2:0] MODE_AVG16 = 3'd4;

    // Number of accepted samples per output update when decimating.
    function automatic logic [CNT_W-1:0] decim_factor(input logic [2:0] m);
        logic [CNT_W-1:0] d;
        d = CNT_W'(1);
        case (m)
            MODE_AVG2:  d = CNT_W'(2);
            MODE_WGT3:  d = CNT_W'(4);
            MODE_AVG4:  d = CNT_W'(4);
            MODE_AVG16: d = CNT_W'(16);
            default:    d = CNT_W'(1);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ma_history.sv
// Sample history shift register; taps[0] is the newest sample, taps[DEPTH-1]
// the oldest.
module ma_history #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      accept,
    input  logic [DW-1:0]             din,
    output logic [DEPTH-1:0][DW-1:0]  taps
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (accept) begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/moving_average.sv
// Selectable-window moving-average filter with optional decimated output.
// Define MOVING_AVERAGE_ROUND_EN to round half up instead of truncating.
module moving_average
    import moving_average_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          data_refresh,
    input  logic          output_refresh_mode,
    input  logic [DW-1:0] din,
    input  logic [2:0]    mode,
    output logic [DW-1:0] dout,
    output logic          output_pulse
);

`ifdef MOVING_AVERAGE_ROUND_EN
    localparam logic [ACC_W-1:0] RND1 = ACC_W'(1);
    localparam logic [ACC_W-1:0] RND2 = ACC_W'(2);
    localparam logic [ACC_W-1:0] RND4 = ACC_W'(8);
`else
    localparam logic [ACC_W-1:0] RND1 = '0;
    localparam logic [ACC_W-1:0] RND2 = '0;
    localparam logic [ACC_W-1:0] RND4 = '0;
`endif

    logic [DEPTH-1:0][DW-1:0] taps;
    logic                     accept;
    logic [ACC_W-1:0]         sum2;
    logic [ACC_W-1:0]         sum4;
    logic [ACC_W-1:0]         wgt3;
    logic [ACC_W-1:0]         sum16;
    logic [DW-1:0]            result;

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_base;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     hit;
    logic                     pending;
    logic                     track_valid;
    logic [2:0]               mode_prev;
    logic                     refresh_prev;
    logic                     cfg_change;

    assign accept = enable & data_refresh;

    ma_history #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_history (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .din    (din),
        .taps   (taps)
    );

    always_comb begin
        sum2  = ACC_W'(taps[0]) + ACC_W'(taps[1]);
        sum4  = sum2 + ACC_W'(taps[2]) + ACC_W'(taps[3]);
        wgt3  = ACC_W'(taps[2]) + ACC_W'(taps[1]) + (ACC_W'(taps[0]) << 1);
        sum16 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum16 = sum16 + ACC_W'(taps[i]);
        end
    end

    // Modes 101..111 deliberately fall through to pass-through.
    always_comb begin
        result = taps[0];
        case (mode)
            MODE_AVG2:  result = DW'((sum2  + RND1) >> 1);
            MODE_WGT3:  result = DW'((wgt3  + RND2) >> 2);
            MODE_AVG4:  result = DW'((sum4  + RND2) >> 2);
            MODE_AVG16: result = DW'((sum16 + RND4) >> 4);
            default:    result = taps[0];
        endcase
    end

    // A config change restarts the decimation window; the same edge's accept
    // then counts as the first sample of the new window.
    assign cfg_change = track_valid &&
                        ((mode != mode_prev) || (output_refresh_mode != refresh_prev));
    assign cnt_base   = cfg_change ? '0 : cnt;
    assign cnt_inc    = cnt_base + CNT_W'(1);
    assign hit        = output_refresh_mode || (cnt_inc >= decim_factor(mode));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            pending      <= 1'b0;
            dout         <= '0;
            output_pulse <= 1'b0;
            track_valid  <= 1'b0;
            mode_prev    <= '0;
            refresh_prev <= 1'b0;
        end else if (enable) begin
            track_valid  <= 1'b1;
            mode_prev    <= mode;
            refresh_prev <= output_refresh_mode;
            output_pulse <= pending;
            if (pending) begin
                dout <= result;
            end
            if (accept) begin
                cnt     <= hit ? '0 : cnt_inc;
                pending <= hit;
            end else begin
                cnt     <= cnt_base;
                pending <= 1'b0;
            end
        end else begin
            // Disabling drops any compute cycle still in flight.
            output_pulse <= 1'b0;
            pending      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average.sv
// Scoreboard bench for moving_average: stimulus queues expected dout values and
// due cycles, a negedge monitor checks every output_pulse against the queue.
module tb_moving_average;
    import moving_average_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        data_refresh;
    logic        output_refresh_mode;
    logic [15:0] din;
    logic [2:0]  mode;
    logic [15:0] dout;
    logic        output_pulse;

`ifdef MOVING_AVERAGE_ROUND_EN
    localparam logic [15:0] E_AVG2 = 16'd5, E_AVG4A = 16'd3, E_AVG4B = 16'd7, E_AVG16 = 16'd9;
`else
    localparam logic [15:0] E_AVG2 = 16'd4, E_AVG4A = 16'd2, E_AVG4B = 16'd6, E_AVG16 = 16'd8;
`endif

    typedef struct {
        logic [15:0] value;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cycle_cnt = 0;
    int   checks    = 0;
    int   fails     = 0;

    moving_average dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .data_refresh        (data_refresh),
        .output_refresh_mode (output_refresh_mode),
        .din                 (din),
        .mode                (mode),
        .dout                (dout),
        .output_pulse        (output_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && output_pulse !== 1'b0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", 32'(output_pulse), 32'd0);
            end else begin
                cur = sb.pop_front();
                checkOutput({cur.tag, "_dout"}, 32'(dout), 32'(cur.value));
                checkOutput({cur.tag, "_latency"}, cycle_cnt, cur.due);
            end
        end
    end

    task automatic pushExpect(input logic [15:0] value, input string tag);
        exp_t e;
        e.value = value;
        e.due   = cycle_cnt + 2;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [15:0] value, input bit expect_pulse,
                                 input logic [15:0] exp_value, input string tag);
        @(negedge clk);
        din          = value;
        data_refresh = 1'b1;
        if (expect_pulse) pushExpect(exp_value, tag);
        @(negedge clk);
        data_refresh = 1'b0;
    endtask

    task automatic doReset(input logic [2:0] m, input logic refresh);
        @(negedge clk);
        rst_n               = 1'b0;
        enable              = 1'b1;
        data_refresh        = 1'b0;
        din                 = '0;
        mode                = m;
        output_refresh_mode = refresh;
        #1;
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_pulse", 32'(output_pulse), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_drained"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [15:0] held;
        rst_n = 1'b1;
        enable = 1'b1;
        data_refresh = 1'b0;
        output_refresh_mode = 1'b1;
        din = '0;
        mode = MODE_PASS;

        doReset(MODE_PASS, 1'b1);
        applyStimulus(16'd1, 1'b1, 16'd1, "pass_1");
        applyStimulus(16'd2, 1'b1, 16'd2, "pass_2");
        applyStimulus(16'd3, 1'b1, 16'd3, "pass_3");
        waitDrain("pass");

        doReset(MODE_AVG2, 1'b0);
        applyStimulus(16'd3, 1'b0, 16'd0, "avg2_a");
        repeat (3) @(negedge clk);
        applyStimulus(16'd6, 1'b1, E_AVG2, "avg2_b");
        waitDrain("avg2");

        doReset(MODE_WGT3, 1'b1);
        applyStimulus(16'd4,  1'b1, 16'd2, "wgt3_a");
        applyStimulus(16'd8,  1'b1, 16'd5, "wgt3_b");
        applyStimulus(16'd12, 1'b1, 16'd9, "wgt3_c");
        waitDrain("wgt3");

        doReset(MODE_AVG4, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(16'(i), (i == 4) || (i == 8), (i == 4) ? E_AVG4A : E_AVG4B,
                          (i == 4) ? "avg4_a" : "avg4_b");
        end
        waitDrain("avg4");

        doReset(MODE_PASS, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            din          = 16'(7 + i);
            data_refresh = 1'b1;
            pushExpect(16'(7 + i), "burst");
            @(negedge clk);
        end
        data_refresh = 1'b0;
        waitDrain("burst");

        doReset(3'd5, 1'b0);
        applyStimulus(16'd42, 1'b1, 16'd42, "mode5");
        waitDrain("mode5");

        doReset(MODE_AVG16, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(16'(i), i == 16, E_AVG16, "avg16");
        end
        waitDrain("avg16");

        held = E_AVG16;
        enable       = 1'b0;
        din          = 16'd100;
        data_refresh = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("disabled_dout", 32'(dout), 32'(held));
            checkOutput("disabled_pulse", 32'(output_pulse), 32'd0);
        end
        data_refresh        = 1'b0;
        enable              = 1'b1;
        mode                = MODE_PASS;
        output_refresh_mode = 1'b1;
        applyStimulus(16'd100, 1'b1, 16'd100, "reenable");
        waitDrain("reenable");

        din          = 16'd55;
        data_refresh = 1'b1;
        @(negedge clk);
        data_refresh = 1'b0;
        enable       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("cancel_dout", 32'(dout), 32'd100);
        enable = 1'b1;
        waitDrain("cancel");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/moving_average.md
Name: moving_average

Overview:
Selectable-window moving-average filter for a 16-bit unsigned sample stream qualified by a strobe. It keeps a 16-deep sample history and computes one of five filter modes. The output updates either on every accepted sample or once per filter window (decimated). It sits between a sample source (ADC/sensor front end) and downstream consumers that take dout on output_pulse.

Parameters:
- DW, 16, sample and output width.
- DEPTH, 16, history depth; fixed to the largest window, not intended for change.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  block enable; when low, strobes are ignored and all state holds.
- data_refresh  in  1  sample strobe; din is accepted on a rising clk edge where enable=1 and data_refresh=1.
- output_refresh_mode  in  1  1: update on every sample; 0: decimate by window size.
- din  in  DW  unsigned input sample.
- mode  in  3  filter select.
- dout  out  DW  filtered result, registered.
- output_pulse  out  1  one-cycle strobe marking a dout update.

Behaviour:
- Reset (async, rst_n=0): history h[0..15]=0; decimation counter=0; dout=0; output_pulse=0; mode-change tracker = current mode.
- Accept edge: history shifts, h[0]=din (newest), h[i]=h[i-1], h[15] discarded. Cycle following the accept edge is the compute cycle.
- Compute cycle edge, modes:
  - 000: dout=h[0]
  - 001: (h0+h1)>>1
  - 010: (h2+h1+2*h0)>>2, i.e. 25% oldest, 25% middle, 50% newest
  - 011: (h0+h1+h2+h3)>>2
  - 100: (sum h0..h15)>>4
  - 101/110/111: treated as 000.
- Arithmetic: unsigned, 20-bit accumulator (no overflow); result truncated toward zero, then low DW bits taken.
- Latency: dout and output_pulse update on the 2nd rising edge after data_refresh is sampled (1-cycle register after the history update). output_pulse is high for exactly one cycle per update.
- Partial history after reset: empty slots are 0 and are averaged as 0. No warm-up suppression.
- output_refresh_mode=1: every accepted sample produces an update + pulse.
- output_refresh_mode=0:
  - Decimation factor D = 1, 2, 4, 4, 16 for modes 000-100; 1 for 101-111.
  - Counter increments on each accept.
  - On the accept that makes the count reach D: counter clears, then update + pulse in the compute cycle.
  - Other accepts: history shifts but dout holds and no pulse.
- Mode change or output_refresh_mode change, detected on the clock: decimation counter clears. History is NOT cleared.
- data_refresh held high across multiple cycles: each enabled cycle is a separate accept.
- enable=0: no accept, no counter change. dout holds and output_pulse=0, including a pending compute cycle, which is cancelled.
- Reset mid-operation: immediate clear per reset list. No pulse on reset release.

Optional Feature:
- MOVING_AVERAGE_ROUND_EN
- Defined: every division adds half an LSB before the shift (+1 for >>1, +2 for >>2, +8 for >>4), giving round-half-up.
- Undefined: plain truncation as specified above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package moving_average_pkg:
  - mode encodings MODE_PASS=3'd0, MODE_AVG2=3'd1, MODE_WGT3=3'd2, MODE_AVG4=3'd3, MODE_AVG16=3'd4
  - accumulator width ACC_W=20
  - function returning decimation factor D for a mode
- One sub-module, ma_history: 16x16 shift register with accept input, exposing all taps.
- Adder tree, mode mux, decimation counter and output register stay in the top.

Test Plan:
- Reset, refresh=1, mode 000, accept 1,2,3 -> dout 1,2,3, one pulse each, exactly two edges after each strobe.
- Reset, refresh=0, mode 001, accept 3,6 -> one pulse after 6, dout=4 (5 with ROUND_EN). The 3 alone gives no pulse.
- Reset, refresh=1, mode 010, accept 4,8,12 -> final dout=(4+8+24)>>2=9.
- Reset, refresh=0, mode 011, accept 1..8 -> pulses only after 4th and 8th samples, dout=2 (floor 2.5) then 6 (floor 6.5); with ROUND_EN 3 then 7.
- Reset, refresh=0, mode 100, accept 1..16 -> single pulse, dout=136>>4=8 (9 with ROUND_EN).
- With dout=8, set enable=0, din=100, data_refresh=1 for 3 cycles -> dout stays 8, output_pulse stays 0. Re-enable with mode 000 and refresh=1, accept 100 -> dout=100.
